// File: rtl/fft_fac8_pkg.sv
// Shared constants for the radix-2^3 FFT twiddle stages: Q1.8 scaling and the
// W8 twiddle values used after the first butterfly.
package fft_fac8_pkg;

    localparam int Q_SHIFT   = 8;
    localparam int TWF_ONE   = 256;
    localparam int TWF_C45   = 181;
    localparam int TWF_NC45  = -181;
    localparam int TWF_NONE  = -256;
    localparam int TWF_ZERO  = 0;

    // Encoding of the sub-path select input
    typedef enum logic [1:0] {
        TWF_SEL_W0 = 2'd0,
        TWF_SEL_NJ = 2'd1,
        TWF_SEL_W1 = 2'd2,
        TWF_SEL_W3 = 2'd3
    } twf_sel_e;

endpackage

// File: rtl/cmul_q8.sv
// Combinational complex multiply by a Q1.8 twiddle followed by an arithmetic
// right shift back to sample scale (floor, no rounding).
module cmul_q8
    import fft_fac8_pkg::*;
#(
    parameter int WIDTH      = 11,
    parameter int TWF_WIDTH  = 10,
    parameter int MUL_WIDTH  = WIDTH + TWF_WIDTH,
    parameter int DOUT_WIDTH = WIDTH + TWF_WIDTH - Q_SHIFT
) (
    input  logic signed [WIDTH-1:0]      re_i,
    input  logic signed [WIDTH-1:0]      im_i,
    input  logic signed [TWF_WIDTH-1:0]  c_i,
    input  logic signed [TWF_WIDTH-1:0]  s_i,
    output logic signed [DOUT_WIDTH-1:0] re_o,
    output logic signed [DOUT_WIDTH-1:0] im_o
);

    localparam int SUM_W = MUL_WIDTH + 1;

    logic signed [SUM_W-1:0] re_full;
    logic signed [SUM_W-1:0] im_full;

    // Operands are widened first so the products and sum never wrap
    assign re_full = SUM_W'(re_i) * SUM_W'(c_i) - SUM_W'(im_i) * SUM_W'(s_i);
    assign im_full = SUM_W'(re_i) * SUM_W'(s_i) + SUM_W'(im_i) * SUM_W'(c_i);

    assign re_o = DOUT_WIDTH'(re_full >>> Q_SHIFT);
    assign im_o = DOUT_WIDTH'(im_full >>> Q_SHIFT);

endmodule

// File: rtl/mul_fac8_1_unit.sv
// Twiddle multiplier after the first radix-2 stage: add path passes through
// at unity gain, sub path is rotated by a selectable W8 factor; one register.
module mul_fac8_1_unit
    import fft_fac8_pkg::*;
#(
    parameter int WIDTH      = 11,
    parameter int TWF_WIDTH  = 10,
    parameter int MUL_WIDTH  = WIDTH + TWF_WIDTH,
    parameter int DOUT_WIDTH = WIDTH + TWF_WIDTH - Q_SHIFT,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   select,
    input  logic                         en,
    input  logic signed [WIDTH-1:0]      din_R_add  [DEPTH],
    input  logic signed [WIDTH-1:0]      din_R_sub  [DEPTH],
    input  logic signed [WIDTH-1:0]      din_Q_add  [DEPTH],
    input  logic signed [WIDTH-1:0]      din_Q_sub  [DEPTH],
    output logic signed [DOUT_WIDTH-1:0] dout_R_add [DEPTH],
    output logic signed [DOUT_WIDTH-1:0] dout_R_sub [DEPTH],
    output logic signed [DOUT_WIDTH-1:0] dout_Q_add [DEPTH],
    output logic signed [DOUT_WIDTH-1:0] dout_Q_sub [DEPTH]
);

    logic signed [TWF_WIDTH-1:0] add_c, add_s;
    logic signed [TWF_WIDTH-1:0] sub_c, sub_s;

    assign add_c = TWF_WIDTH'(TWF_ONE);
    assign add_s = TWF_WIDTH'(TWF_ZERO);

    always_comb begin
        sub_c = TWF_WIDTH'(TWF_ONE);
        sub_s = TWF_WIDTH'(TWF_ZERO);
        case (twf_sel_e'(select))
            TWF_SEL_W0: begin
                sub_c = TWF_WIDTH'(TWF_ONE);
                sub_s = TWF_WIDTH'(TWF_ZERO);
            end
            TWF_SEL_NJ: begin
                sub_c = TWF_WIDTH'(TWF_ZERO);
                sub_s = TWF_WIDTH'(TWF_NONE);
            end
            TWF_SEL_W1: begin
                sub_c = TWF_WIDTH'(TWF_C45);
                sub_s = TWF_WIDTH'(TWF_NC45);
            end
            TWF_SEL_W3: begin
                sub_c = TWF_WIDTH'(TWF_NC45);
                sub_s = TWF_WIDTH'(TWF_NC45);
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_lane
            logic signed [DOUT_WIDTH-1:0] r_add_d, q_add_d, r_sub_d, q_sub_d;
            logic signed [DOUT_WIDTH-1:0] r_add_q, q_add_q, r_sub_q, q_sub_q;

            cmul_q8 #(
                .WIDTH      (WIDTH),
                .TWF_WIDTH  (TWF_WIDTH),
                .MUL_WIDTH  (MUL_WIDTH),
                .DOUT_WIDTH (DOUT_WIDTH)
            ) u_cmul_add (
                .re_i (din_R_add[gi]),
                .im_i (din_Q_add[gi]),
                .c_i  (add_c),
                .s_i  (add_s),
                .re_o (r_add_d),
                .im_o (q_add_d)
            );

            cmul_q8 #(
                .WIDTH      (WIDTH),
                .TWF_WIDTH  (TWF_WIDTH),
                .MUL_WIDTH  (MUL_WIDTH),
                .DOUT_WIDTH (DOUT_WIDTH)
            ) u_cmul_sub (
                .re_i (din_R_sub[gi]),
                .im_i (din_Q_sub[gi]),
                .c_i  (sub_c),
                .s_i  (sub_s),
                .re_o (r_sub_d),
                .im_o (q_sub_d)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_add_q <= '0;
                    q_add_q <= '0;
                    r_sub_q <= '0;
                    q_sub_q <= '0;
                end else if (en) begin
                    r_add_q <= r_add_d;
                    q_add_q <= q_add_d;
                    r_sub_q <= r_sub_d;
                    q_sub_q <= q_sub_d;
                end
            end

            assign dout_R_add[gi] = r_add_q;
            assign dout_Q_add[gi] = q_add_q;
            assign dout_R_sub[gi] = r_sub_q;
            assign dout_Q_sub[gi] = q_sub_q;
        end
    endgenerate

endmodule

// File: tb/tb_mul_fac8_1_unit.sv
// Self-checking bench for mul_fac8_1_unit: directed cases plus random
// traffic compared against a complex-arithmetic reference model.
module tb_mul_fac8_1_unit;

    localparam int WIDTH = 11;
    localparam int TWF_WIDTH = 10;
    localparam int DOUT_WIDTH = 13;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] select = 2'd0;
    logic en = 1'b0;
    logic signed [WIDTH-1:0] din_R_add [DEPTH];
    logic signed [WIDTH-1:0] din_R_sub [DEPTH];
    logic signed [WIDTH-1:0] din_Q_add [DEPTH];
    logic signed [WIDTH-1:0] din_Q_sub [DEPTH];
    logic signed [DOUT_WIDTH-1:0] dout_R_add [DEPTH];
    logic signed [DOUT_WIDTH-1:0] dout_R_sub [DEPTH];
    logic signed [DOUT_WIDTH-1:0] dout_Q_add [DEPTH];
    logic signed [DOUT_WIDTH-1:0] dout_Q_sub [DEPTH];

    int checks = 0;
    int failures = 0;

    // Expected register contents: [0]=R_add [1]=Q_add [2]=R_sub [3]=Q_sub
    int exp_q [4][DEPTH];

    always #5 clk = ~clk;

    mul_fac8_1_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .select     (select),
        .en         (en),
        .din_R_add  (din_R_add),
        .din_R_sub  (din_R_sub),
        .din_Q_add  (din_Q_add),
        .din_Q_sub  (din_Q_sub),
        .dout_R_add (dout_R_add),
        .dout_R_sub (dout_R_sub),
        .dout_Q_add (dout_Q_add),
        .dout_Q_sub (dout_Q_sub)
    );

    task automatic check_eq(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    // W8 twiddle for the sub path as real numbers scaled by 256
    function automatic void twiddle(input int sel, output int c, output int s);
        case (sel)
            0: begin c = 256;  s = 0;    end
            1: begin c = 0;    s = -256; end
            2: begin c = 181;  s = -181; end
            default: begin c = -181; s = -181; end
        endcase
    endfunction

    function automatic int floor_div256(input int x);
        int q;
        q = x / 256;
        if ((x % 256 != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_load();
        int c, s, r, q;
        twiddle(int'(select), c, s);
        for (int i = 0; i < DEPTH; i++) begin
            exp_q[0][i] = int'(din_R_add[i]);
            exp_q[1][i] = int'(din_Q_add[i]);
            r = int'(din_R_sub[i]);
            q = int'(din_Q_sub[i]);
            exp_q[2][i] = floor_div256(r * c - q * s);
            exp_q[3][i] = floor_div256(r * s + q * c);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < DEPTH; i++) exp_q[k][i] = 0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            check_eq($sformatf("%s R_add[%0d]", tag, i), int'(dout_R_add[i]), exp_q[0][i]);
            check_eq($sformatf("%s Q_add[%0d]", tag, i), int'(dout_Q_add[i]), exp_q[1][i]);
            check_eq($sformatf("%s R_sub[%0d]", tag, i), int'(dout_R_sub[i]), exp_q[2][i]);
            check_eq($sformatf("%s Q_sub[%0d]", tag, i), int'(dout_Q_sub[i]), exp_q[3][i]);
        end
    endtask

    task automatic drive_const(input int ra, input int rs, input int qa, input int qs);
        for (int i = 0; i < DEPTH; i++) begin
            din_R_add[i] = WIDTH'(ra);
            din_R_sub[i] = WIDTH'(rs);
            din_Q_add[i] = WIDTH'(qa);
            din_Q_sub[i] = WIDTH'(qs);
        end
    endtask

    task automatic drive_rand();
        for (int i = 0; i < DEPTH; i++) begin
            din_R_add[i] = WIDTH'(int'($urandom_range(2047)) - 1024);
            din_R_sub[i] = WIDTH'(int'($urandom_range(2047)) - 1024);
            din_Q_add[i] = WIDTH'(int'($urandom_range(2047)) - 1024);
            din_Q_sub[i] = WIDTH'(int'($urandom_range(2047)) - 1024);
        end
    endtask

    // One clock: model follows the DUT register, outputs sampled 1 time unit later
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) model_clear();
        else if (en) model_load();
        #1;
        check_all(tag);
        $display("txn %s sel=%0d en=%0d rst_n=%0d R_sub0=%0d Q_sub0=%0d",
                 tag, select, en, rst_n, dout_R_sub[0], dout_Q_sub[0]);
    endtask

    task automatic spot(input string tag, input int ra, input int qa, input int rs, input int qs);
        check_eq({tag, " lit R_add"}, int'(dout_R_add[DEPTH-1]), ra);
        check_eq({tag, " lit Q_add"}, int'(dout_Q_add[DEPTH-1]), qa);
        check_eq({tag, " lit R_sub"}, int'(dout_R_sub[DEPTH-1]), rs);
        check_eq({tag, " lit Q_sub"}, int'(dout_Q_sub[DEPTH-1]), qs);
    endtask

    initial begin
        model_clear();
        drive_rand();
        en = 1'b1;
        select = 2'd2;
        rst_n = 1'b0;
        #3;
        check_all("reset_async");
        tick("reset_hold");
        tick("reset_hold");

        // Release between edges with en low: outputs must stay zero
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        tick("post_reset_idle");
        tick("post_reset_idle");

        // Directed twiddle cases with the same lane data
        @(negedge clk);
        drive_const(1, -2, 3, -4);
        en = 1'b1;
        select = 2'd0;
        tick("sel0");
        spot("sel0", 1, 3, -2, -4);
        select = 2'd1;
        tick("sel1");
        spot("sel1", 1, 3, -4, 2);
        select = 2'd2;
        tick("sel2");
        spot("sel2", 1, 3, -5, -2);
        select = 2'd3;
        tick("sel3");
        spot("sel3", 1, 3, -2, 4);

        // Most-negative inputs on the 45-degree twiddles
        drive_const(-1024, -1024, -1024, -1024);
        select = 2'd2;
        tick("ext_sel2");
        spot("ext_sel2", -1024, -1024, -1448, 0);
        select = 2'd3;
        tick("ext_sel3");
        spot("ext_sel3", -1024, -1024, 0, 1448);

        // Hold: inputs and select change but en is low
        en = 1'b0;
        drive_rand();
        select = 2'd1;
        tick("hold");
        spot("hold", -1024, -1024, 0, 1448);
        tick("hold");

        // Random traffic with random enable and select
        for (int n = 0; n < 200; n++) begin
            drive_rand();
            select = 2'($urandom_range(3));
            en = ($urandom_range(7) != 0);
            tick("rand");
        end

        // Async reset between edges while enabled clears at once
        en = 1'b1;
        drive_rand();
        tick("pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all("async_clear");
        #1;
        rst_n = 1'b1;
        drive_rand();
        select = 2'd3;
        tick("after_async");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
